// File: rtl/sigcapture.sv
// sigcapture: triggered capture buffer.
// After an arm request the block watches the accepted sample stream for a
// strict rising crossing of trig_level, then stores exactly DEPTH consecutive
// strobed samples into on-chip RAM. The RAM is readable at any time through
// a registered read port.
module sigcapture #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     arm,
  input  logic [DATA_WIDTH-1:0]    trig_level,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     armed,
  output logic                     capturing,
  output logic                     done,
  output logic [ADDRESS_WIDTH:0]   count
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
  // count value just before the record becomes full (DEPTH-1)
  localparam logic [ADDRESS_WIDTH:0] LAST = {1'b0, {ADDRESS_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    prev_q, prev_d;
  logic                     prev_valid_q, prev_valid_d;
  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0]    dout_q, dout_d;
  logic                     armed_q, armed_d;
  logic                     capturing_q, capturing_d;
  logic                     done_q, done_d;

  logic                     trigger;
  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  // Strict rising crossing: previous accepted sample below level, current at or above.
  always_comb begin
    trigger = en && prev_valid_q && (prev_q < trig_level) && (din >= trig_level);
  end

  // Next-state, write request and readback selection.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    wr_en        = 1'b0;
    wr_addr      = wr_ptr_q;

    unique case (state_q)
      S_IDLE: begin
        prev_valid_d = 1'b0;
        count_d      = '0;
        // a sample strobed alongside arm is neither stored nor remembered
        if (arm) begin
          state_d = S_ARMED;
        end
      end

      S_ARMED: begin
        if (en) begin
          prev_d       = din;
          prev_valid_d = 1'b1;
          if (trigger) begin
            wr_en    = 1'b1;
            wr_addr  = '0;
            wr_ptr_d = ADDRESS_WIDTH'(1);
            count_d  = (ADDRESS_WIDTH + 1)'(1);
            state_d  = S_CAPTURE;
          end
        end
      end

      S_CAPTURE: begin
        if (en) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDRESS_WIDTH'(1);
          count_d  = count_q + (ADDRESS_WIDTH + 1)'(1);
          if (count_q == LAST) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (arm) begin
          state_d      = S_ARMED;
          prev_valid_d = 1'b0;
          count_d      = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // status flags are registered from the next state so they track state_q exactly
    armed_d     = (state_d == S_ARMED);
    capturing_d = (state_d == S_CAPTURE);
    done_d      = (state_d == S_DONE);

    // read happens before this edge's write lands, so a collision returns old data
    dout_d = mem[rd_addr];
  end

  // Control and status registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      armed_q      <= 1'b0;
      capturing_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      armed_q      <= armed_d;
      capturing_q  <= capturing_d;
      done_q       <= done_d;
    end
  end

  // Sample RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= din;
    end
  end

  assign dout      = dout_q;
  assign armed     = armed_q;
  assign capturing = capturing_q;
  assign done      = done_q;
  assign count     = count_q;

endmodule

// File: tb/tb_sigcapture.sv
// Self-checking bench for sigcapture: directed scenarios plus a random soak,
// all checked against a record-queue model of the capture behaviour.
module tb_sigcapture;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_CAP   = 2;
  localparam int M_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] din;
  logic          arm;
  logic [DW-1:0] trig_level;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] dout;
  logic          armed;
  logic          capturing;
  logic          done;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  sigcapture #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din       (din),
    .arm       (arm),
    .trig_level(trig_level),
    .rd_addr   (rd_addr),
    .dout      (dout),
    .armed     (armed),
    .capturing (capturing),
    .done      (done),
    .count     (count)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // reference model: current record as a queue, memory image as an array
  int m_mode = M_IDLE;
  int m_prev = 0;
  bit m_have_prev = 1'b0;
  int rec[$];
  int mem_m [DEPTH];
  bit mem_ok[DEPTH];
  int exp_dout = 0;
  bit exp_dout_ok = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_store(input int v);
    mem_m[rec.size() % DEPTH]  = v;
    mem_ok[rec.size() % DEPTH] = 1'b1;
    rec.push_back(v);
  endfunction

  function automatic void model_reset();
    m_mode      = M_IDLE;
    m_have_prev = 1'b0;
    rec.delete();
    exp_dout    = 0;
    exp_dout_ok = 1'b1;
  endfunction

  // apply one clock edge with the currently driven inputs
  function automatic void model_edge();
    int d;
    int t;
    d = int'(din);
    t = int'(trig_level);
    exp_dout_ok = mem_ok[rd_addr];
    exp_dout    = mem_m[rd_addr];
    case (m_mode)
      M_IDLE, M_DONE: begin
        if (arm) begin
          m_mode      = M_ARMED;
          m_have_prev = 1'b0;
          rec.delete();
        end
      end
      M_ARMED: begin
        if (en) begin
          if (m_have_prev && m_prev < t && d >= t) begin
            rec.delete();
            model_store(d);
            m_mode = M_CAP;
          end
          m_prev      = d;
          m_have_prev = 1'b1;
        end
      end
      M_CAP: begin
        if (en) begin
          model_store(d);
          if (rec.size() == DEPTH) m_mode = M_DONE;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endfunction

  task automatic check_outputs();
    check_val("armed",     32'(armed),     32'(m_mode == M_ARMED));
    check_val("capturing", 32'(capturing), 32'(m_mode == M_CAP));
    check_val("done",      32'(done),      32'(m_mode == M_DONE));
    check_val("count",     32'(count),     32'(rec.size()));
    if (exp_dout_ok) check_val("dout", 32'(dout), 32'(exp_dout));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  // asynchronous reset asserted between edges, checked before the next edge
  task automatic mid_reset();
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    en  = 1'b0;
    step();
    arm = 1'b0;
  endtask

  // feed random strobed samples until the record completes
  task automatic run_to_done(input string tag);
    for (int i = 0; i < 2000 && !done; i++) begin
      en      = 1'b1;
      din     = DW'($urandom_range(0, 255));
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      step();
    end
    check_val(tag, 32'(done), 32'd1);
  endtask

  task automatic read_expect(input string tag, input int addr, input int exp);
    en      = 1'b0;
    rd_addr = AW'(addr);
    step();
    check_val(tag, 32'(dout), 32'(exp));
  endtask

  int saved[$];
  int old_val;
  int gap_cycles;
  int col_addr;

  initial begin
    rst        = 1'b0;
    en         = 1'b0;
    din        = '0;
    arm        = 1'b0;
    trig_level = '0;
    rd_addr    = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs();
    check_val("reset_dout", 32'(dout), 32'd0);
    rst = 1'b1;

    // idle then arm: armed visible the cycle after the pulse
    step();
    arm_pulse();
    check_val("arm_to_armed", 32'(armed), 32'd1);

    // basic trigger on a ramp of step 4 crossing 128
    trig_level = 8'd128;
    for (int k = 0; k < 400 && !done; k++) begin
      en      = 1'b1;
      din     = DW'(120 + 4 * k);
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      step();
    end
    check_val("basic_done",  32'(done),  32'd1);
    check_val("basic_count", 32'(count), 32'd256);
    read_expect("basic_mem0", 0, 128);
    read_expect("basic_mem1", 1, 132);

    // strict crossing: trig_level 0 never fires, a held high level never fires
    arm_pulse();
    trig_level = 8'd0;
    for (int i = 0; i < 40; i++) begin
      en  = 1'b1;
      din = DW'($urandom_range(0, 255));
      step();
    end
    check_val("trig0_still_armed", 32'(armed), 32'd1);
    trig_level = 8'd100;
    for (int i = 0; i < 20; i++) begin
      en  = 1'b1;
      din = 8'd200;
      step();
    end
    check_val("held_high_armed", 32'(armed), 32'd1);
    din = 8'd50;
    step();
    din = 8'd150;
    step();
    check_val("strict_trig", 32'(capturing), 32'd1);
    run_to_done("strict_done");
    read_expect("strict_mem0", 0, 150);

    // gapped strobe: 1,0,1,0 pattern from the trigger cycle onward
    arm_pulse();
    en  = 1'b1;
    din = 8'd50;
    step();
    din = 8'd150;
    step();
    gap_cycles = 1;
    for (int i = 0; i < 1200 && !done; i++) begin
      en  = (i % 2) == 1;
      din = DW'($urandom_range(0, 255));
      step();
      gap_cycles++;
    end
    check_val("gap_done", 32'(done), 32'd1);
    // 256 two-clock strobe periods; the last write lands on the first clock
    // of the final period, i.e. edge 511 counting the trigger edge as edge 1
    check_val("gap_cycles", 32'(gap_cycles), 32'd511);
    for (int a = 0; a < DEPTH; a++) begin
      en      = 1'b0;
      rd_addr = AW'(a);
      step();
    end

    // arm ignored during capture, same-address read/write returns old data
    arm_pulse();
    en  = 1'b1;
    din = 8'd50;
    step();
    din = 8'd150;
    step();
    for (int i = 0; i < 5; i++) begin
      din = DW'($urandom_range(0, 255));
      step();
    end
    arm = 1'b1;
    din = DW'($urandom_range(0, 255));
    step();
    arm = 1'b0;
    check_val("arm_ignored", 32'(capturing), 32'd1);
    col_addr = rec.size() % DEPTH;
    old_val  = mem_m[col_addr];
    rd_addr  = AW'(col_addr);
    din      = DW'(old_val ^ 8'h5A);
    step();
    check_val("rw_collision", 32'(dout), 32'(old_val));
    en = 1'b0;
    step();
    run_to_done("rearm_done");

    // arm and en together in DONE: sample neither stored nor used as prev
    trig_level = 8'd100;
    arm = 1'b1;
    en  = 1'b1;
    din = 8'd50;
    step();
    arm = 1'b0;
    check_val("arm_en_count", 32'(count), 32'd0);
    din = 8'd150;
    step();
    check_val("no_trig_prev_invalid", 32'(armed), 32'd1);
    din = 8'd20;
    step();
    din = 8'd120;
    step();
    check_val("retrig", 32'(capturing), 32'd1);

    // reset after 10 captured samples; the record stays readable
    run_to_done("pre_reset_done");
    arm_pulse();
    en  = 1'b1;
    din = 8'd50;
    step();
    din = 8'd150;
    step();
    for (int i = 0; i < 9; i++) begin
      din = DW'($urandom_range(0, 255));
      step();
    end
    check_val("ten_captured", 32'(count), 32'd10);
    saved = rec;
    mid_reset();
    check_val("reset_count0", 32'(count), 32'd0);
    for (int a = 0; a < 10; a++) begin
      read_expect("keep_after_reset", a, saved[a]);
    end

    // random soak
    for (int i = 0; i < 3000; i++) begin
      arm = ($urandom_range(0, 39) == 0);
      en  = ($urandom_range(0, 3) != 0);
      din = DW'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) trig_level = DW'($urandom_range(0, 255));
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
